// File: rtl/hdmi_audio_pkg.sv
// hdmi_audio_pkg: shared constants for HDMI audio sample packet decoding
package hdmi_audio_pkg;
  localparam logic [7:0] PACKET_TYPE_AUDIO_SAMPLE = 8'd2;
  localparam int CHANNEL_STATUS_LENGTH = 192;
  localparam int SAMPLE_W = 24;
  localparam int SUB_W = 56;
  localparam int SUB_LEFT_LSB = 0;
  localparam int SUB_RIGHT_LSB = 24;
  localparam int SUB_V_LEFT = 48;
  localparam int SUB_U_LEFT = 49;
  localparam int SUB_C_LEFT = 50;
  localparam int SUB_P_LEFT = 51;
  localparam int SUB_V_RIGHT = 52;
  localparam int SUB_U_RIGHT = 53;
  localparam int SUB_C_RIGHT = 54;
  localparam int SUB_P_RIGHT = 55;
  localparam int HDR_TYPE_LSB = 0;
  localparam int HDR_PRESENT_LSB = 8;
  localparam int HDR_LAYOUT_BIT = 12;
  localparam int HDR_B_LSB = 20;
endpackage

// File: rtl/audio_channel_status_collector.sv
// audio_channel_status_collector: frames C bits into 192-bit blocks using B as the block-start marker
module audio_channel_status_collector
  import hdmi_audio_pkg::*;
(
  input  logic                             clk_pixel,
  input  logic                             reset_n,
  input  logic                             sample_fire,
  input  logic                             b_flag,
  input  logic                             c_left,
  input  logic                             c_right,
  output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_left,
  output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_right,
  output logic                             cs_update,
  output logic                             cs_sync_error
);
  localparam logic [7:0] LAST_IDX = 8'(CHANNEL_STATUS_LENGTH - 1);
  logic synced, synced_n, write, publish, sync_err, in_block;
  logic [7:0] idx, idx_n;
  logic [CHANNEL_STATUS_LENGTH-1:0] acc_l, acc_r, acc_l_n, acc_r_n;
  always_comb begin
    in_block = synced && idx != LAST_IDX;
    synced_n = sample_fire ? (b_flag || in_block) : synced;
    idx_n = !sample_fire ? idx : b_flag ? 8'd0 : in_block ? idx + 8'd1 : idx;
    write = sample_fire && (b_flag || in_block);
    sync_err = sample_fire && b_flag && in_block;
    acc_l_n = acc_l;
    acc_r_n = acc_r;
    if (write) begin
      acc_l_n[idx_n] = c_left;
      acc_r_n[idx_n] = c_right;
    end
    publish = write && idx_n == LAST_IDX;
  end
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      synced <= 1'b0;
      idx <= '0;
      acc_l <= '0;
      acc_r <= '0;
      channel_status_left <= '0;
      channel_status_right <= '0;
      cs_update <= 1'b0;
      cs_sync_error <= 1'b0;
    end else begin
      synced <= synced_n;
      idx <= idx_n;
      acc_l <= acc_l_n;
      acc_r <= acc_r_n;
      cs_update <= publish;
      cs_sync_error <= sync_err;
      if (publish) begin
        channel_status_left <= acc_l_n;
        channel_status_right <= acc_r_n;
      end
    end
endmodule

// File: rtl/audio_sample_packet_decoder.sv
// audio_sample_packet_decoder: buffers one audio sample packet and streams its present subpackets in index order
module audio_sample_packet_decoder
  import hdmi_audio_pkg::*;
(
  input  logic                             clk_pixel,
  input  logic                             reset_n,
  input  logic                             packet_valid,
  input  logic [23:0]                      header,
  input  logic [3:0][SUB_W-1:0]            sub,
  output logic                             sample_valid,
  input  logic                             sample_ready,
  output logic [SAMPLE_W-1:0]              sample_left,
  output logic [SAMPLE_W-1:0]              sample_right,
  output logic [1:0]                       valid_bit,
  output logic [1:0]                       user_bit,
  output logic [1:0]                       parity_error,
  output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_left,
  output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_right,
  output logic                             cs_update,
  output logic                             cs_sync_error,
  output logic                             packet_dropped,
  output logic                             packet_unsupported
);
  logic [3:0] mask, b_flags, low;
  logic [3:0][SUB_W-1:0] buf_q;
  logic [1:0] sel;
  logic [SUB_W-1:0] cur;
  logic fire, last, is_audio, layout, accept, unused_hdr;
  assign unused_hdr = ^header[19:13];
  always_comb begin
    low = mask & (~mask + 4'd1);
    sel = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    cur = buf_q[sel];
    sample_valid = |mask;
    fire = sample_valid && sample_ready;
    last = fire && (mask & ~low) == 4'd0;
    is_audio = packet_valid && header[HDR_TYPE_LSB +: 8] == PACKET_TYPE_AUDIO_SAMPLE;
    layout = header[HDR_LAYOUT_BIT];
    accept = is_audio && !layout && (!sample_valid || last);
    sample_left = cur[SUB_LEFT_LSB +: SAMPLE_W];
    sample_right = cur[SUB_RIGHT_LSB +: SAMPLE_W];
    valid_bit = {cur[SUB_V_RIGHT], cur[SUB_V_LEFT]};
    user_bit = {cur[SUB_U_RIGHT], cur[SUB_U_LEFT]};
    parity_error = {^{cur[SUB_P_RIGHT -: 4], cur[SUB_RIGHT_LSB +: SAMPLE_W]},
                    ^{cur[SUB_P_LEFT -: 4], cur[SUB_LEFT_LSB +: SAMPLE_W]}};
  end
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      mask <= '0;
      b_flags <= '0;
      buf_q <= '0;
      packet_dropped <= 1'b0;
      packet_unsupported <= 1'b0;
    end else begin
      packet_dropped <= is_audio && !layout && !accept;
      packet_unsupported <= is_audio && layout;
      if (accept) begin
        mask <= header[HDR_PRESENT_LSB +: 4];
        b_flags <= header[HDR_B_LSB +: 4];
        buf_q <= sub;
      end else if (fire)
        mask <= mask & ~low;
    end
  audio_channel_status_collector u_cs (
    .clk_pixel            (clk_pixel),
    .reset_n              (reset_n),
    .sample_fire          (fire),
    .b_flag               (|(b_flags & low)),
    .c_left               (cur[SUB_C_LEFT]),
    .c_right              (cur[SUB_C_RIGHT]),
    .channel_status_left  (channel_status_left),
    .channel_status_right (channel_status_right),
    .cs_update            (cs_update),
    .cs_sync_error        (cs_sync_error)
  );
endmodule

// File: doc/audio_sample_packet_decoder.md
AUDIO_SAMPLE_PACKET_DECODER -- requirements
Module: audio_sample_packet_decoder

Interface
REQ-001 SHALL have port clk_pixel, input, 1 bit: the single clock for all logic.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port packet_valid, input, 1 bit: one-cycle strobe marking header/sub as a received, ECC-checked packet.
REQ-004 SHALL have port header, input, 24 bits: [7:0] type, [11:8] sample_present sp0..3, [12] layout, [23:20] B flags sp0..3.
REQ-005 SHALL have port sub[3:0], input, 56 bits each: [23:0] left, [47:24] right, [48..51] V/U/C/P left, [52..55] V/U/C/P right.
REQ-006 SHALL have port sample_valid, output, 1 bit, plus input sample_ready, 1 bit: output stream handshake.
REQ-007 SHALL have ports sample_left and sample_right, output, 24 bits each: sample words.
REQ-008 SHALL have ports valid_bit, user_bit and parity_error, output, 2 bits each: per-sample {right,left}, qualified by sample_valid.
REQ-009 SHALL have ports channel_status_left and channel_status_right, output, 192 bits each: last complete channel-status block.
REQ-010 SHALL have port cs_update, output, 1 bit: one-cycle pulse when a new block is published.
REQ-011 SHALL have port cs_sync_error, output, 1 bit: one-cycle pulse when B arrives early.
REQ-012 SHALL have ports packet_dropped and packet_unsupported, output, 1 bit each: one-cycle pulses.

Function
REQ-013 SHALL accept a packet only when packet_valid=1, header[7:0]=8'd2 and header[12]=0.
REQ-014 SHALL ignore a packet with type != 2 with no pulse.
REQ-015 SHALL ignore a packet with type 2 and layout=1, pulsing packet_unsupported.
REQ-016 SHALL latch all four subpackets and the present mask into a pending buffer on accept.
REQ-017 SHALL emit pending entries in ascending subpacket index, one per handshake, skipping non-present entries.
REQ-018 SHALL drive sample_valid=1 from cycle N+1 when the packet is accepted at cycle N and sp0 is present.
REQ-019 SHALL hold all sample outputs stable while sample_valid=1 and sample_ready=0.
REQ-020 SHALL accept a new packet when the pending buffer is empty or its last entry completes a handshake in the same cycle; otherwise it SHALL discard the packet and pulse packet_dropped.
REQ-021 SHALL accept a packet with present mask 4'b0000 as a no-op that emits no sample.
REQ-022 SHALL set parity_error[k]=1 when P differs from the XOR of C, U, V and all 24 sample bits of that subframe; the sample SHALL still be emitted.
REQ-023 SHALL update the channel-status frame index only on each emitted sample.
REQ-024 SHALL set the index to 0 when the sample's B=1, otherwise increment it; it SHALL then write C_left/C_right into bit [index] of the accumulators.
REQ-025 SHALL ignore C bits until the first B=1 after reset (unsynced state).
REQ-026 SHALL copy the accumulators to channel_status_* and pulse cs_update when a sample is written at index 191; the next sample without B SHALL drop sync.
REQ-027 SHALL pulse cs_sync_error on B=1 while synced and index != 191, then restart at index 0; no publish SHALL occur.

Reset
REQ-028 SHALL, while reset_n=0, clear all outputs, the pending buffer, the accumulators, the index and sync.
REQ-029 SHALL, on reset assertion mid-drain, immediately discard the remaining samples.

Structure
REQ-030 SHALL place in package hdmi_audio_pkg: PACKET_TYPE_AUDIO_SAMPLE=8'd2, CHANNEL_STATUS_LENGTH=192, and the subpacket bit-offset constants.
REQ-031 SHALL place channel-status sync/accumulate/publish (REQ-023..027) in one sub-module, audio_channel_status_collector.

Verification
REQ-032 SHALL cover: one packet, mask 4'b1111, ready held 1 -> four samples on consecutive cycles starting N+1 in sp0..sp3 order.
REQ-033 SHALL cover: sp1 P bit flipped -> that sample has parity_error=2'b01 or 2'b10, all others 0.
REQ-034 SHALL cover: 192 samples, B on first -> exactly one cs_update after sample 192; outputs equal the driven C pattern (e.g. left bits[27:24]=4'd1).
REQ-035 SHALL cover: B reasserted at sample 100 -> cs_sync_error pulse, no cs_update, next block publishes correctly.
REQ-036 SHALL cover: ready held 0 with a second packet -> packet_dropped pulse; second packet arriving on the last handshake -> accepted.
REQ-037 SHALL cover: reset_n low mid-drain -> sample_valid=0 asynchronously, no residual samples after release; layout=1 -> packet_unsupported only.
